secded_scrub: RTL
=================

SECDED_SCRUB -- requirements
Module: secded_scrub

Interface
REQ-001 Parameter DEPTH, default 4: pending-scrub queue entries, power of two, 2..16.
REQ-002 Parameter CNT_W, default 32: width of error counters.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 err_single_i  input  1  registered single-bit-error flag from the SECDED checker.
REQ-006 err_double_i  input  1  registered double-bit-error flag from the SECDED checker.
REQ-007 err_addr_i  input  32  address of the word that produced the flags.
REQ-008 corr_data_i  input  32  corrected 32-bit data for err_addr_i.
REQ-009 scrub_req_o  output  1  request for the memory write port.
REQ-010 scrub_gnt_i  input  1  grant; the arbiter holds core accesses off while high.
REQ-011 scrub_we_o  output  1  write strobe to the SECDED encoder/memory, one cycle.
REQ-012 scrub_addr_o  output  32  write address.
REQ-013 scrub_wdata_o  output  32  corrected data, re-encoded downstream.
REQ-014 irq_o  output  1  level interrupt.
REQ-015 cyc_i, stb_i, we_i  input  1 each  Wishbone slave controls.
REQ-016 adr_i, dat_i  input  32 each  Wishbone address and write data.
REQ-017 dat_o  output  32  Wishbone read data.
REQ-018 ack_o  output  1  Wishbone ack.

Function
REQ-019 Registers: CTRL (bit0 enable, reset 1; bit1 irq_en, reset 0; bit2 write-1 clears counters/sticky bits, self-clearing), STATUS (read-only: [4:0] queue occupancy, bit8 overflow sticky, bit9 double-error sticky), SCNT, DCNT, DADDR (last double-error address).
REQ-020 Ack SHALL assert for exactly one cycle, one cycle after cyc_i&stb_i first seen high, and deassert before a new access is accepted; unmapped addresses read 0, writes ignored.
REQ-021 On an err_single_i rising edge with enable=1: push {err_addr_i, corr_data_i} into the queue; SCNT increments.
REQ-022 A push whose address equals the most recently pushed address still queued SHALL be discarded (no counter change).
REQ-023 Queue full on push: entry dropped, overflow sticky set, SCNT still increments.
REQ-024 On an err_double_i rising edge: DCNT increments, DADDR <= err_addr_i, double sticky set; never queued.
REQ-025 Counters saturate at all-ones; no wrap.
REQ-026 FSM IDLE -> REQ when queue non-empty and enable=1; REQ holds scrub_req_o=1 until scrub_gnt_i=1 -> WR.
REQ-027 WR: scrub_we_o=1 with head address/data for exactly one cycle, pop head -> HOLD.
REQ-028 HOLD: one idle cycle with req low (lets the core in) -> IDLE.
REQ-029 Push and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-030 Enable cleared in REQ before grant: drop request, return to IDLE, queue retained; cleared in WR/HOLD: current write completes.
REQ-031 Clear (CTRL bit2) same cycle as an increment: clear wins.
REQ-032 irq_o = irq_en & (overflow | double sticky).
REQ-033 scrub_addr_o/scrub_wdata_o SHALL be stable from REQ entry to WR exit.

Reset
REQ-034 Reset: FSM IDLE, queue empty, counters/DADDR/stickies 0, enable 1, irq_en 0; all outputs 0.
REQ-035 Reset mid-REQ/WR SHALL drop scrub_req_o/scrub_we_o immediately (asynchronously); queued entries lost.

Structure
REQ-036 Register addresses (SCRUB_CTRL/STATUS/SCNT/DCNT/DADDR, within the 0x0000_06xx SECDED window) and FSM state encodings belong in defines.v.
REQ-037 The queue SHALL be a sub-module scrub_fifo (DEPTH x 64 bits, push/pop/full/empty/count).

Verification
REQ-038 Single error addr 0x100 data 0xDEADBEEF, grant after 3 cycles -> req high 3 cycles, one we pulse with 0x100/0xDEADBEEF, SCNT=1.
REQ-039 err_single_i high 5 cycles same address -> one queue entry, SCNT=1.
REQ-040 Six distinct single errors, grant held low -> occupancy 4, overflow=1, SCNT=6; irq_o=1 once irq_en set.
REQ-041 Double error at 0x2C -> DCNT=1, DADDR=0x2C, no scrub_req_o.
REQ-042 Push in the WR cycle of a prior entry -> occupancy unchanged, both writes issued in order.
REQ-043 rst_i low during REQ -> scrub_req_o low same cycle, STATUS reads 0 after release.

Source files
------------

// File: rtl/secded_scrub_pkg.sv
// Shared definitions for the SECDED scrubber: register map, FSM states, queue entry layout.
package secded_scrub_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Register map inside the 0x0000_06xx SECDED window
    localparam logic [ADDR_W-1:0] SCRUB_CTRL   = 32'h0000_0600;
    localparam logic [ADDR_W-1:0] SCRUB_STATUS = 32'h0000_0604;
    localparam logic [ADDR_W-1:0] SCRUB_SCNT   = 32'h0000_0608;
    localparam logic [ADDR_W-1:0] SCRUB_DCNT   = 32'h0000_060C;
    localparam logic [ADDR_W-1:0] SCRUB_DADDR  = 32'h0000_0610;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_CLR_BIT    = 2;
    localparam int unsigned STAT_OVF_BIT    = 8;
    localparam int unsigned STAT_DBL_BIT    = 9;

    // Scrub write-back sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WR   = 2'd2,
        ST_HOLD = 2'd3
    } scrub_state_e;

    // One pending scrub: where to write and the corrected word
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } scrub_entry_t;

endpackage

// File: rtl/scrub_fifo.sv
// Pending-scrub queue: DEPTH entries of {addr, data}, simultaneous push/pop allowed.
module scrub_fifo
    import secded_scrub_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  scrub_entry_t           din_i,
    output scrub_entry_t           head_c_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    scrub_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            full_q;
    logic            empty_q;
    logic            do_push;
    logic            do_pop;

    // A push into a full queue is accepted only when the head leaves in the same cycle
    assign do_pop  = pop_i & ~empty_q;
    assign do_push = push_i & (~full_q | do_pop);

    // Occupancy next-state
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointers and status flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = cnt_q;

endmodule

// File: rtl/secded_scrub.sv
// SECDED scrubber: queues corrected single-bit errors and writes them back through an
// arbitrated memory port; counts single/double errors behind a Wishbone register block.
module secded_scrub
    import secded_scrub_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              err_single_i,
    input  logic              err_double_i,
    input  logic [ADDR_W-1:0] err_addr_i,
    input  logic [DATA_W-1:0] corr_data_i,
    output logic              scrub_req_o,
    input  logic              scrub_gnt_i,
    output logic              scrub_we_o,
    output logic [ADDR_W-1:0] scrub_addr_o,
    output logic [DATA_W-1:0] scrub_wdata_o,
    output logic              irq_o,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    scrub_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic [DATA_W-1:0] swdata_q, swdata_d;

    logic              sgl_prev_q, dbl_prev_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic              dbl_q, dbl_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic              irq_q, irq_d;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic [31:0]       rdata_c;
    logic [31:0]       status_c;

    scrub_entry_t      head;
    scrub_entry_t      push_entry;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic              sgl_rise, dbl_rise;
    logic              dup, take, push, pop, ovf_set;
    logic              wb_req, ctrl_wr, clr;
    logic              unused_c;

    assign unused_c = ^dat_i[31:3];

    assign wb_req  = cyc_i & stb_i & ~ack_q;
    assign ctrl_wr = wb_req & we_i & (adr_i == SCRUB_CTRL);
    assign clr     = ctrl_wr & dat_i[CTRL_CLR_BIT];

    // A repeat of the newest queued address is dropped; a full queue drops but still counts
    assign sgl_rise = err_single_i & ~sgl_prev_q;
    assign dbl_rise = err_double_i & ~dbl_prev_q;
    assign dup      = sgl_rise & en_q & ~fifo_empty & (err_addr_i == last_addr_q);
    assign take     = sgl_rise & en_q & ~dup;
    assign pop      = (state_q == ST_WR);
    assign push     = take & (~fifo_full | pop);
    assign ovf_set  = take & fifo_full & ~pop;

    assign push_entry = '{addr: err_addr_i, data: corr_data_i};

    scrub_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push),
        .pop_i    (pop),
        .din_i    (push_entry),
        .head_c_o (head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_cnt)
    );

    // Write-back sequencer next state; address/data latched on REQ entry stay put through WR
    always_comb begin
        state_d  = state_q;
        req_d    = 1'b0;
        we_d     = 1'b0;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && en_q) begin
                    state_d  = ST_REQ;
                    saddr_d  = head.addr;
                    swdata_d = head.data;
                end
            end
            ST_REQ: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (scrub_gnt_i) begin
                    state_d = ST_WR;
                end
            end
            ST_WR:   state_d = ST_HOLD;
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_REQ);
        we_d  = (state_d == ST_WR);
    end

    // Sequencer state and its registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            saddr_q  <= '0;
            swdata_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
        end
    end

    // Control, saturating counters and sticky flags; a clear beats a same-cycle increment
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        scnt_d   = scnt_q;
        dcnt_d   = dcnt_q;
        daddr_d  = daddr_q;
        ovf_d    = ovf_q | ovf_set;
        dbl_d    = dbl_q | dbl_rise;
        if (ctrl_wr) begin
            en_d     = dat_i[CTRL_EN_BIT];
            irq_en_d = dat_i[CTRL_IRQ_EN_BIT];
        end
        if (take && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
        if (dbl_rise) begin
            daddr_d = err_addr_i;
            if (dcnt_q != '1) dcnt_d = dcnt_q + CNT_W'(1);
        end
        if (clr) begin
            scnt_d = '0;
            dcnt_d = '0;
            ovf_d  = 1'b0;
            dbl_d  = 1'b0;
        end
        irq_d = irq_en_d & (ovf_d | dbl_d);
    end

    // Register-block and error-edge state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sgl_prev_q  <= 1'b0;
            dbl_prev_q  <= 1'b0;
            last_addr_q <= '0;
            en_q        <= 1'b1;
            irq_en_q    <= 1'b0;
            scnt_q      <= '0;
            dcnt_q      <= '0;
            daddr_q     <= '0;
            ovf_q       <= 1'b0;
            dbl_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sgl_prev_q  <= err_single_i;
            dbl_prev_q  <= err_double_i;
            if (push) last_addr_q <= err_addr_i;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            scnt_q      <= scnt_d;
            dcnt_q      <= dcnt_d;
            daddr_q     <= daddr_d;
            ovf_q       <= ovf_d;
            dbl_q       <= dbl_d;
            irq_q       <= irq_d;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_c               = '0;
        status_c[4:0]          = 5'(fifo_cnt);
        status_c[STAT_OVF_BIT] = ovf_q;
        status_c[STAT_DBL_BIT] = dbl_q;
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rdata_c = '0;
        case (adr_i)
            SCRUB_CTRL:   rdata_c = {30'b0, irq_en_q, en_q};
            SCRUB_STATUS: rdata_c = status_c;
            SCRUB_SCNT:   rdata_c = 32'(scnt_q);
            SCRUB_DCNT:   rdata_c = 32'(dcnt_q);
            SCRUB_DADDR:  rdata_c = daddr_q;
            default:      rdata_c = '0;
        endcase
    end

    // Single-cycle Wishbone ack with read data registered alongside it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= wb_req;
            dat_q <= (wb_req && !we_i) ? rdata_c : '0;
        end
    end

    assign scrub_req_o   = req_q;
    assign scrub_we_o    = we_q;
    assign scrub_addr_o  = saddr_q;
    assign scrub_wdata_o = swdata_q;
    assign irq_o         = irq_q;
    assign ack_o         = ack_q;
    assign dat_o         = dat_q;

endmodule
